// File: rtl/wr_burst_arbiter_if.sv
// wr_burst_arbiter_if
//   Bundles the requester side (per-channel burst/tail requests with lengths,
//   grant and completion pulses) and the downstream command side (command
//   handshake, completion, busy) of the write-burst arbiter.
//
//   Parameters: NUM   number of requesting channels
//               LSIZE width of one burst length field
//               IDW   width of the channel id
//
//   Modports:   slave  - the arbiter itself
//               master - the environment (FSC channels + AXI write master)
interface wr_burst_arbiter_if #(
  parameter int NUM   = 4,
  parameter int LSIZE = 9,
  parameter int IDW   = 2
);

  // Requester side
  logic [NUM-1:0]       burst_req;
  logic [NUM-1:0]       tail_req;
  logic [NUM*LSIZE-1:0] req_len;
  logic [NUM-1:0]       resp;
  logic [NUM-1:0]       done;

  // Downstream command side
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [LSIZE-1:0]     cmd_len;
  logic [IDW-1:0]       cmd_id;
  logic                 cmd_tail;
  logic                 cmd_done;

  // Status
  logic                 busy;

  modport slave (
    input  burst_req, tail_req, req_len, cmd_ready, cmd_done,
    output resp, done, cmd_valid, cmd_len, cmd_id, cmd_tail, busy
  );

  modport master (
    output burst_req, tail_req, req_len, cmd_ready, cmd_done,
    input  resp, done, cmd_valid, cmd_len, cmd_id, cmd_tail, busy
  );

endinterface

// File: rtl/wr_burst_arbiter.sv
// wr_burst_arbiter
//   Shares one AXI write-burst command port among NUM write-side FIFO status
//   controllers. Requests are arbitrated round-robin; the winner receives a
//   one-cycle resp pulse, a command is issued downstream, and a one-cycle
//   done pulse is returned to the winner once the write master reports the
//   burst complete.
//
//   Ports:
//     clock  system clock
//     rst    asynchronous, active-high reset
//     bus    wr_burst_arbiter_if.slave
//              burst_req/tail_req  per-channel level requests, held until resp
//              req_len             per-channel length, channel i at [i*LSIZE +: LSIZE]
//              resp/done           one-hot single-cycle grant / completion pulses
//              cmd_valid/ready     downstream command handshake
//              cmd_len/id/tail     granted command, stable while outstanding
//              cmd_done            single-cycle completion from the write master
//              busy                high whenever the FSM is not idle
//
//   Build option:
//     TAIL_PRIORITY_EN  when defined, tail requests win over burst requests
//                       (round-robin over tail_req only while any tail is
//                       pending, sharing one pointer). When undefined, burst
//                       and tail requests are equal priority.
module wr_burst_arbiter #(
  parameter int NUM   = 4,
  parameter int LSIZE = 9,
  parameter int IDW   = 2
) (
  input logic               clock,
  input logic               rst,
  wr_burst_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;

  logic [NUM-1:0]   arb_req;
  logic             found;
  logic [IDW-1:0]   win;
  logic [NUM-1:0]   win_oh;
  logic [LSIZE-1:0] win_len;
  logic             win_tail;
  logic [NUM-1:0]   id_oh;
  logic [IDW-1:0]   next_ptr;

  // Request vector seen by the round-robin search.
`ifdef TAIL_PRIORITY_EN
  always_comb begin
    arb_req = bus.burst_req | bus.tail_req;
    if (|bus.tail_req) begin
      arb_req = bus.tail_req;
    end
  end
`else
  always_comb begin
    arb_req = bus.burst_req | bus.tail_req;
  end
`endif

  // Round-robin search: first pass covers [ptr, NUM-1], second pass wraps to
  // [0, ptr-1]. Using two constant-index passes avoids a variable modulo index.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_oh   = '0;
    win_len  = '0;
    win_tail = 1'b0;
    for (int unsigned j = 0; j < NUM; j++) begin
      if (!found && (j >= 32'(ptr)) && arb_req[j]) begin
        found     = 1'b1;
        win       = IDW'(j);
        win_oh    = '0;
        win_oh[j] = 1'b1;
        win_len   = bus.req_len[j*LSIZE +: LSIZE];
        win_tail  = bus.tail_req[j];
      end
    end
    for (int unsigned j = 0; j < NUM; j++) begin
      if (!found && (j < 32'(ptr)) && arb_req[j]) begin
        found     = 1'b1;
        win       = IDW'(j);
        win_oh    = '0;
        win_oh[j] = 1'b1;
        win_len   = bus.req_len[j*LSIZE +: LSIZE];
        win_tail  = bus.tail_req[j];
      end
    end
  end

  // One-hot of the granted channel, used for the done pulse.
  always_comb begin
    id_oh = '0;
    for (int unsigned j = 0; j < NUM; j++) begin
      if (bus.cmd_id == IDW'(j)) begin
        id_oh[j] = 1'b1;
      end
    end
  end

  assign next_ptr = (bus.cmd_id == IDW'(NUM - 1)) ? '0 : bus.cmd_id + 1'b1;

  // Single FSM; every output is a register. resp/done default low each cycle
  // so they can only ever be single-cycle pulses, and they are set from
  // different states so they are never high together.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      bus.resp      <= '0;
      bus.done      <= '0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_len   <= '0;
      bus.cmd_id    <= '0;
      bus.cmd_tail  <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.resp <= '0;
      bus.done <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            state         <= ISSUE;
            bus.resp      <= win_oh;
            bus.cmd_id    <= win;
            bus.cmd_len   <= win_len;
            bus.cmd_tail  <= win_tail;
            bus.cmd_valid <= (win_len != '0);
            bus.busy      <= 1'b1;
          end
        end

        ISSUE: begin
          if (bus.cmd_len == '0) begin
            // Zero-length grant: acknowledge only, no downstream command.
            state    <= DONE;
            bus.done <= id_oh;
            ptr      <= next_ptr;
          end else if (bus.cmd_ready) begin
            bus.cmd_valid <= 1'b0;
            if (bus.cmd_done) begin
              state    <= DONE;
              bus.done <= id_oh;
              ptr      <= next_ptr;
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (bus.cmd_done) begin
            state    <= DONE;
            bus.done <= id_oh;
            ptr      <= next_ptr;
          end
        end

        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wr_burst_arbiter.sv
module tb_wr_burst_arbiter;

  localparam int NUM   = 4;
  localparam int LSIZE = 9;
  localparam int IDW   = 2;

  logic clock;
  logic rst;
  int   tests;
  int   fails;

  wr_burst_arbiter_if #(.NUM(NUM), .LSIZE(LSIZE), .IDW(IDW)) bus ();

  wr_burst_arbiter #(.NUM(NUM), .LSIZE(LSIZE), .IDW(IDW)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic clear_inputs();
    bus.burst_req = '0;
    bus.tail_req  = '0;
    bus.req_len   = '0;
    bus.cmd_ready = 1'b0;
    bus.cmd_done  = 1'b0;
  endtask

  // Leaves the bench at a falling edge with rst released and the DUT idle.
  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1;
    clear_inputs();
    @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic pulse_cmd_done();
    bus.cmd_done = 1'b1;
    @(negedge clock);
    bus.cmd_done = 1'b0;
  endtask

  task automatic set_len(input int ch, input logic [LSIZE-1:0] len);
    bus.req_len[ch*LSIZE +: LSIZE] = len;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clock);
    tests++; if (bus.resp !== 4'b0000) begin fails++; $display("FAIL reset_resp: got %b expected 0000", bus.resp); end
    tests++; if (bus.done !== 4'b0000) begin fails++; $display("FAIL reset_done: got %b expected 0000", bus.done); end
    tests++; if (bus.cmd_valid !== 1'b0) begin fails++; $display("FAIL reset_cmd_valid: got %b expected 0", bus.cmd_valid); end
    tests++; if (bus.cmd_tail !== 1'b0) begin fails++; $display("FAIL reset_cmd_tail: got %b expected 0", bus.cmd_tail); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.cmd_len !== 9'd0) begin fails++; $display("FAIL reset_cmd_len: got %0d expected 0", bus.cmd_len); end
    tests++; if (bus.cmd_id !== 2'd0) begin fails++; $display("FAIL reset_cmd_id: got %0d expected 0", bus.cmd_id); end
    @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    do_reset();
    set_len(0, 9'd200);
    bus.burst_req = 4'b0001;
    bus.cmd_ready = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (bus.resp == '0 && n < 20);
    tests++; if (n !== 1) begin fails++; $display("FAIL single_latency: got %0d cycles expected 1", n); end
    tests++; if (bus.resp !== 4'b0001) begin fails++; $display("FAIL single_resp: got %b expected 0001", bus.resp); end
    tests++; if (bus.cmd_valid !== 1'b1) begin fails++; $display("FAIL single_cmd_valid: got %b expected 1", bus.cmd_valid); end
    tests++; if (bus.cmd_len !== 9'd200) begin fails++; $display("FAIL single_cmd_len: got %0d expected 200", bus.cmd_len); end
    tests++; if (bus.cmd_id !== 2'd0) begin fails++; $display("FAIL single_cmd_id: got %0d expected 0", bus.cmd_id); end
    tests++; if (bus.cmd_tail !== 1'b0) begin fails++; $display("FAIL single_cmd_tail: got %b expected 0", bus.cmd_tail); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy_issue: got %b expected 1", bus.busy); end
    bus.burst_req = '0;
    @(negedge clock);
    tests++; if (bus.resp !== 4'b0000) begin fails++; $display("FAIL single_resp_once: got %b expected 0000", bus.resp); end
    tests++; if (bus.cmd_valid !== 1'b0) begin fails++; $display("FAIL single_valid_drop: got %b expected 0", bus.cmd_valid); end
    repeat (9) @(negedge clock);
    tests++; if (bus.done !== 4'b0000) begin fails++; $display("FAIL single_early_done: got %b expected 0000", bus.done); end
    pulse_cmd_done();
    tests++; if (bus.done !== 4'b0001) begin fails++; $display("FAIL single_done: got %b expected 0001", bus.done); end
    tests++; if (bus.resp !== 4'b0000) begin fails++; $display("FAIL single_resp_at_done: got %b expected 0000", bus.resp); end
    @(negedge clock);
    tests++; if (bus.done !== 4'b0000) begin fails++; $display("FAIL single_done_once: got %b expected 0000", bus.done); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_contention();
    int n;
    logic [3:0] exp_oh;
    logic [3:0] order2 [2];
    logic [1:0] order2_id [2];
    do_reset();
    bus.cmd_ready = 1'b1;
    for (int c = 0; c < NUM; c++) set_len(c, LSIZE'(10 + c));
    bus.burst_req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp_oh = 4'b0001 << k;
      n = 0;
      do begin @(negedge clock); n++; end while (bus.resp == '0 && n < 20);
      tests++; if (bus.resp !== exp_oh) begin fails++; $display("FAIL rr_resp[%0d]: got %b expected %b", k, bus.resp, exp_oh); end
      tests++; if (bus.cmd_len !== LSIZE'(10 + k)) begin fails++; $display("FAIL rr_len[%0d]: got %0d expected %0d", k, bus.cmd_len, 10 + k); end
      bus.burst_req = bus.burst_req & ~exp_oh;
      @(negedge clock);
      pulse_cmd_done();
      tests++; if (bus.done !== exp_oh) begin fails++; $display("FAIL rr_done[%0d]: got %b expected %b", k, bus.done, exp_oh); end
      @(negedge clock);
      tests++; if (bus.done !== 4'b0000) begin fails++; $display("FAIL rr_done_once[%0d]: got %b expected 0000", k, bus.done); end
    end
    order2[0] = 4'b0001; order2_id[0] = 2'd0;
    order2[1] = 4'b1000; order2_id[1] = 2'd3;
    bus.burst_req = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin @(negedge clock); n++; end while (bus.resp == '0 && n < 20);
      tests++; if (bus.resp !== order2[k]) begin fails++; $display("FAIL rr2_resp[%0d]: got %b expected %b", k, bus.resp, order2[k]); end
      tests++; if (bus.cmd_id !== order2_id[k]) begin fails++; $display("FAIL rr2_id[%0d]: got %0d expected %0d", k, bus.cmd_id, order2_id[k]); end
      bus.burst_req = bus.burst_req & ~order2[k];
      @(negedge clock);
      pulse_cmd_done();
      tests++; if (bus.done !== order2[k]) begin fails++; $display("FAIL rr2_done[%0d]: got %b expected %b", k, bus.done, order2[k]); end
      @(negedge clock);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int extra;
    do_reset();
    bus.cmd_ready = 1'b0;
    set_len(1, 9'd77);
    bus.burst_req = 4'b0010;
    n = 0;
    do begin @(negedge clock); n++; end while (bus.resp == '0 && n < 20);
    tests++; if (bus.resp !== 4'b0010) begin fails++; $display("FAIL bp_resp: got %b expected 0010", bus.resp); end
    tests++; if (bus.cmd_id !== 2'd1) begin fails++; $display("FAIL bp_id: got %0d expected 1", bus.cmd_id); end
    bus.burst_req = '0;
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (bus.resp != '0) extra++;
      tests++;
      if ({bus.cmd_valid, bus.cmd_len, bus.cmd_id} !== {1'b1, 9'd77, 2'd1}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got valid=%b len=%0d id=%0d expected valid=1 len=77 id=1", k, bus.cmd_valid, bus.cmd_len, bus.cmd_id);
      end
    end
    tests++; if (extra !== 0) begin fails++; $display("FAIL bp_resp_once: got %0d extra pulses expected 0", extra); end
    bus.cmd_ready = 1'b1;
    bus.cmd_done  = 1'b1;
    @(negedge clock);
    bus.cmd_ready = 1'b0;
    bus.cmd_done  = 1'b0;
    tests++; if (bus.done !== 4'b0010) begin fails++; $display("FAIL bp_done: got %b expected 0010", bus.done); end
    tests++; if (bus.cmd_valid !== 1'b0) begin fails++; $display("FAIL bp_valid_drop: got %b expected 0", bus.cmd_valid); end
    @(negedge clock);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL bp_busy_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_tail();
    int n;
    do_reset();
    bus.cmd_ready = 1'b1;
    set_len(2, 9'd37);
    bus.tail_req = 4'b0100;
    n = 0;
    do begin @(negedge clock); n++; end while (bus.resp == '0 && n < 20);
    tests++; if (bus.resp !== 4'b0100) begin fails++; $display("FAIL tail_resp: got %b expected 0100", bus.resp); end
    tests++; if (bus.cmd_tail !== 1'b1) begin fails++; $display("FAIL tail_flag: got %b expected 1", bus.cmd_tail); end
    tests++; if (bus.cmd_len !== 9'd37) begin fails++; $display("FAIL tail_len: got %0d expected 37", bus.cmd_len); end
    tests++; if (bus.cmd_id !== 2'd2) begin fails++; $display("FAIL tail_id: got %0d expected 2", bus.cmd_id); end
    bus.tail_req = '0;
    @(negedge clock);
    pulse_cmd_done();
    tests++; if (bus.done !== 4'b0100) begin fails++; $display("FAIL tail_done: got %b expected 0100", bus.done); end
    @(negedge clock);
    // Both request kinds on one channel are treated as a tail.
    set_len(3, 9'd5);
    bus.burst_req = 4'b1000;
    bus.tail_req  = 4'b1000;
    n = 0;
    do begin @(negedge clock); n++; end while (bus.resp == '0 && n < 20);
    tests++; if (bus.resp !== 4'b1000) begin fails++; $display("FAIL both_resp: got %b expected 1000", bus.resp); end
    tests++; if (bus.cmd_tail !== 1'b1) begin fails++; $display("FAIL both_tail: got %b expected 1", bus.cmd_tail); end
    tests++; if (bus.cmd_len !== 9'd5) begin fails++; $display("FAIL both_len: got %0d expected 5", bus.cmd_len); end
    bus.burst_req = '0;
    bus.tail_req  = '0;
    @(negedge clock);
    pulse_cmd_done();
    @(negedge clock);
  endtask

  task automatic test_zero_len();
    int n;
    do_reset();
    bus.cmd_ready = 1'b1;
    set_len(1, 9'd0);
    bus.burst_req = 4'b0010;
    n = 0;
    do begin @(negedge clock); n++; end while (bus.resp == '0 && n < 20);
    tests++; if (bus.resp !== 4'b0010) begin fails++; $display("FAIL zero_resp: got %b expected 0010", bus.resp); end
    tests++; if (bus.cmd_valid !== 1'b0) begin fails++; $display("FAIL zero_no_valid: got %b expected 0", bus.cmd_valid); end
    bus.burst_req = '0;
    @(negedge clock);
    tests++; if (bus.done !== 4'b0010) begin fails++; $display("FAIL zero_done: got %b expected 0010", bus.done); end
    tests++; if (bus.cmd_valid !== 1'b0) begin fails++; $display("FAIL zero_no_valid_done: got %b expected 0", bus.cmd_valid); end
    @(negedge clock);
    tests++; if ({bus.done, bus.busy} !== 5'b0) begin fails++; $display("FAIL zero_idle: got done=%b busy=%b expected done=0000 busy=0", bus.done, bus.busy); end
  endtask

  task automatic test_priority();
    int n;
    logic [3:0] exp_oh;
    logic       exp_tail;
`ifdef TAIL_PRIORITY_EN
    exp_oh   = 4'b0100;
    exp_tail = 1'b1;
`else
    exp_oh   = 4'b0001;
    exp_tail = 1'b0;
`endif
    do_reset();
    bus.cmd_ready = 1'b1;
    for (int c = 0; c < NUM; c++) set_len(c, LSIZE'(20 + c));
    bus.burst_req = 4'b0011;
    bus.tail_req  = 4'b0100;
    n = 0;
    do begin @(negedge clock); n++; end while (bus.resp == '0 && n < 20);
    tests++; if (bus.resp !== exp_oh) begin fails++; $display("FAIL prio_resp: got %b expected %b", bus.resp, exp_oh); end
    tests++; if (bus.cmd_tail !== exp_tail) begin fails++; $display("FAIL prio_tail: got %b expected %b", bus.cmd_tail, exp_tail); end
    bus.burst_req = '0;
    bus.tail_req  = '0;
    @(negedge clock);
    pulse_cmd_done();
    @(negedge clock);
  endtask

  task automatic test_reset_mid_burst();
    int n;
    do_reset();
    bus.cmd_ready = 1'b1;
    // Complete one grant on channel 1 so the pointer moves to 2.
    set_len(1, 9'd4);
    bus.burst_req = 4'b0010;
    n = 0;
    do begin @(negedge clock); n++; end while (bus.resp == '0 && n < 20);
    tests++; if (bus.resp !== 4'b0010) begin fails++; $display("FAIL mid_pre_resp: got %b expected 0010", bus.resp); end
    bus.burst_req = '0;
    @(negedge clock);
    pulse_cmd_done();
    @(negedge clock);
    set_len(2, 9'd10);
    bus.burst_req = 4'b0100;
    n = 0;
    do begin @(negedge clock); n++; end while (bus.resp == '0 && n < 20);
    tests++; if (bus.resp !== 4'b0100) begin fails++; $display("FAIL mid_resp: got %b expected 0100", bus.resp); end
    bus.burst_req = '0;
    @(negedge clock);
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL mid_wait_busy: got %b expected 1", bus.busy); end
    rst = 1'b1;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.cmd_id !== 2'd0) begin fails++; $display("FAIL mid_rst_id: got %0d expected 0", bus.cmd_id); end
    tests++; if (bus.cmd_len !== 9'd0) begin fails++; $display("FAIL mid_rst_len: got %0d expected 0", bus.cmd_len); end
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    pulse_cmd_done();
    tests++; if (bus.done !== 4'b0000) begin fails++; $display("FAIL mid_late_done: got %b expected 0000", bus.done); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mid_late_busy: got %b expected 0", bus.busy); end
    set_len(0, 9'd8);
    set_len(2, 9'd9);
    bus.burst_req = 4'b0101;
    n = 0;
    do begin @(negedge clock); n++; end while (bus.resp == '0 && n < 20);
    tests++; if (bus.resp !== 4'b0001) begin fails++; $display("FAIL mid_ptr_reset: got %b expected 0001", bus.resp); end
    bus.burst_req = '0;
    @(negedge clock);
    pulse_cmd_done();
    @(negedge clock);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_tail();
    test_zero_len();
    test_priority();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
